mem_bus_ctrl: RTL and testbench

//  Memory-side responder for the CPU control signals rd_mem/wr_mem/byt.

---
 rtl/mem_bus_ctrl_if.sv | 28 ++
 rtl/mem_bus_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: CPU request/response and byte-wide memory bus of mem_bus_ctrl.
// master = CPU plus memory environment, slave = the controller.
interface mem_bus_ctrl_if;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        rd_mem;
   logic        wr_mem;
   logic        byt;
   logic [15:0] rdata;
   logic        rvalid;
   logic        busy;
   logic        err;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   modport master (
      output addr, wdata, rd_mem, wr_mem, byt, mem_rdata,
      input  rdata, rvalid, busy, err, mem_addr, mem_wdata, mem_re, mem_we
   );

   modport slave (
      input  addr, wdata, rd_mem, wr_mem, byt, mem_rdata,
      output rdata, rvalid, busy, err, mem_addr, mem_wdata, mem_re, mem_we
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: splits 16-bit CPU word/byte accesses into byte cycles on a byte-wide memory bus.
// Define MEMBUS_UNALIGNED_EN to let word accesses start at odd addresses.
module mem_bus_ctrl #(
   parameter int RD_LAT  = 1,
   parameter int WAIT_ST = 0
) (
   input logic           clk,
   input logic           rst_n,
   mem_bus_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD_LO, RD_WAIT_LO, RD_HI, RD_WAIT_HI, WR_LO, WR_HI, WAIT} state_t;

   state_t      state, state_n;
   logic [1:0]  cnt, cnt_n;
   logic        hi_q, hi_n;
   logic [15:0] base_q, base_n;
   logic [7:0]  lo_q, lo_n;
   logic [7:0]  wr_hi_q, wr_hi_n;
   logic [15:0] rdata_n, mem_addr_n;
   logic [7:0]  mem_wdata_n;
   logic        rvalid_n, err_n;
   logic        accept;
   logic [15:0] acc_addr;

   assign accept = (state == IDLE) && (bus.rd_mem || bus.wr_mem);

`ifdef MEMBUS_UNALIGNED_EN
   assign acc_addr = bus.addr;
`else
   assign acc_addr = bus.byt ? bus.addr : {bus.addr[15:1], 1'b0};
`endif

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hi_n        = hi_q;
      base_n      = base_q;
      lo_n        = lo_q;
      wr_hi_n     = wr_hi_q;
      rdata_n     = bus.rdata;
      mem_addr_n  = bus.mem_addr;
      mem_wdata_n = bus.mem_wdata;
      rvalid_n    = 1'b0;
      err_n       = 1'b0;
      case (state)
         IDLE: if (accept) begin
            state_n     = bus.wr_mem ? WR_LO : RD_LO;
            hi_n        = !bus.byt;
            base_n      = acc_addr;
            wr_hi_n     = bus.wdata[15:8];
            err_n       = bus.rd_mem && bus.wr_mem;
            mem_addr_n  = acc_addr;
            mem_wdata_n = bus.wdata[7:0];
         end
         RD_LO, RD_HI: begin
            state_n = (state == RD_LO) ? RD_WAIT_LO : RD_WAIT_HI;
            cnt_n   = 2'(RD_LAT - 1);
         end
         RD_WAIT_LO: if (cnt != 2'd0) cnt_n = cnt - 2'd1;
         else if (hi_q) begin
            state_n    = RD_HI;
            lo_n       = bus.mem_rdata;
            mem_addr_n = base_q + 16'd1;
         end else begin
            state_n  = IDLE;
            rvalid_n = 1'b1;
            rdata_n  = {8'h00, bus.mem_rdata};
         end
         RD_WAIT_HI: if (cnt != 2'd0) cnt_n = cnt - 2'd1;
         else begin
            state_n  = IDLE;
            rvalid_n = 1'b1;
            rdata_n  = {bus.mem_rdata, lo_q};
         end
         // each written byte is followed by WAIT_ST idle cycles before the next byte or release
         WR_LO, WR_HI, WAIT: if (state != WAIT && WAIT_ST > 0) begin
            state_n = WAIT;
            cnt_n   = 2'(WAIT_ST - 1);
         end else if (state == WAIT && cnt != 2'd0) cnt_n = cnt - 2'd1;
         else if (hi_q) begin
            state_n     = WR_HI;
            hi_n        = 1'b0;
            mem_addr_n  = base_q + 16'd1;
            mem_wdata_n = wr_hi_q;
         end else state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         hi_q          <= 1'b0;
         base_q        <= '0;
         lo_q          <= '0;
         wr_hi_q       <= '0;
         bus.rdata     <= '0;
         bus.rvalid    <= 1'b0;
         bus.busy      <= 1'b0;
         bus.err       <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_re    <= 1'b0;
         bus.mem_we    <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         hi_q          <= hi_n;
         base_q        <= base_n;
         lo_q          <= lo_n;
         wr_hi_q       <= wr_hi_n;
         bus.rdata     <= rdata_n;
         bus.rvalid    <= rvalid_n;
         bus.busy      <= state_n != IDLE;
         bus.err       <= err_n;
         bus.mem_addr  <= mem_addr_n;
         bus.mem_wdata <= mem_wdata_n;
         bus.mem_re    <= state_n inside {RD_LO, RD_HI};
         bus.mem_we    <= state_n inside {WR_LO, WR_HI};
      end
   end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: two controller configurations (RD_LAT=1/WAIT_ST=0 and RD_LAT=3/WAIT_ST=1)
// driven in lockstep, each checked every cycle against a transaction-schedule model.
module tb_mem_bus_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] s_addr = '0, s_wdata = '0;
   logic        s_rd = 1'b0, s_wr = 1'b0, s_byt = 1'b0;
   int          cyc = 0, checks = 0, errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      case (a)
         16'h0101: return 8'hA5;
         16'h0234: return 8'h12;
         16'h0235: return 8'hAB;
         16'hFFFE: return 8'h11;
         16'hFFFF: return 8'h22;
         16'h0000: return 8'h33;
         default:  return a[7:0] ^ a[15:8] ^ 8'h5C;
      endcase
   endfunction

   task automatic check(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, g, cyc, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : 3;
      localparam int W = (g == 0) ? 0 : 1;
      mem_bus_ctrl_if bus();
      mem_bus_ctrl #(.RD_LAT(L), .WAIT_ST(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
      assign bus.addr   = s_addr;
      assign bus.wdata  = s_wdata;
      assign bus.rd_mem = s_rd;
      assign bus.wr_mem = s_wr;
      assign bus.byt    = s_byt;

      logic [7:0]  mem [0:65535];
      logic [7:0]  ref_mem [0:65535];
      logic [7:0]  md = 8'hEE;
      logic [2:0]  pv = '0;
      logic [15:0] pa [3];
      assign bus.mem_rdata = md;
      initial for (int i = 0; i < 65536; i++) begin
         mem[i]     = init_byte(16'(i));
         ref_mem[i] = init_byte(16'(i));
      end

      // memory: strobes are sampled on the next edge, read data appears L edges later
      always @(posedge clk) begin
         if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
         pv    = {pv[1:0], bus.mem_re};
         pa[2] = pa[1];
         pa[1] = pa[0];
         pa[0] = bus.mem_addr;
         md   <= pv[L-1] ? mem[pa[L-1]] : 8'hEE;
      end

      // model: t = cycles since the accept edge, T = cycle at which busy is released
      bit          m_act = 1'b0, m_wr = 1'b0, m_both = 1'b0;
      int          m_t = 0, m_T = 0, m_p = 1, m_n = 1;
      logic [15:0] m_a = '0, m_d = '0, exp_rd = '0;
      logic        m_busy;
      assign m_busy = m_act && (m_t < m_T);

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_act  = 1'b0;
            m_t    = 0;
            m_T    = 0;
            exp_rd = '0;
         end else if (m_act && m_t < m_T) begin
            m_t++;
            if (m_t == m_T) begin
               if (m_wr) for (int k = 0; k < m_n; k++) ref_mem[m_a + 16'(k)] = (k == 0) ? m_d[7:0] : m_d[15:8];
               else exp_rd = (m_n == 1) ? {8'h00, ref_mem[m_a]} : {ref_mem[m_a + 16'd1], ref_mem[m_a]};
            end
         end else if (s_rd || s_wr) begin
            m_act  = 1'b1;
            m_t    = 0;
            m_wr   = s_wr;
            m_both = s_rd && s_wr;
            m_n    = s_byt ? 1 : 2;
`ifdef MEMBUS_UNALIGNED_EN
            m_a    = s_addr;
`else
            m_a    = s_byt ? s_addr : (s_addr & 16'hFFFE);
`endif
            m_d    = s_wdata;
            m_p    = s_wr ? 1 + W : L + 1;
            m_T    = m_n * m_p;
         end else m_act = 1'b0;
      end

      always @(negedge clk) begin : cmp
         bit es;
         int k;
         es = m_busy && (m_t % m_p == 0);
         k  = m_busy ? m_t / m_p : 0;
         check("busy", g, bus.busy, m_busy);
         check("mem_re", g, bus.mem_re, es && !m_wr);
         check("mem_we", g, bus.mem_we, es && m_wr);
         check("rvalid", g, bus.rvalid, m_act && !m_wr && m_t == m_T);
         check("err", g, bus.err, m_act && m_t == 0 && m_both);
         check("rdata", g, bus.rdata, exp_rd);
         if (es) check("mem_addr", g, bus.mem_addr, m_a + 16'(k));
         if (es && m_wr) check("mem_wdata", g, bus.mem_wdata, (k == 0) ? m_d[7:0] : m_d[15:8]);
      end

      int  rv_cyc = 0, done_cyc = 0, rv_cnt = 0, err_cnt = 0, we_cnt = 0;
      logic [15:0] rv_data = '0;
      bit  busy_q = 1'b0;
      always @(negedge clk) begin
         if (bus.rvalid) begin
            rv_cyc  = cyc;
            rv_data = bus.rdata;
            rv_cnt++;
         end
         if (busy_q && !bus.busy) done_cyc = cyc;
         busy_q = bus.busy;
         if (bus.err) err_cnt++;
         if (bus.mem_we) we_cnt++;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((g_dut[0].m_busy || g_dut[1].m_busy) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 0, n >= 60, 0);
      @(negedge clk);
   endtask

   task automatic do_req(input bit rd, input bit wr, input bit byt, input logic [15:0] a, input logic [15:0] d, output int acc);
      s_rd    = rd;
      s_wr    = wr;
      s_byt   = byt;
      s_addr  = a;
      s_wdata = d;
      @(negedge clk);
      acc  = cyc;
      s_rd = 1'b0;
      s_wr = 1'b0;
      wait_idle();
   endtask

   initial begin
      int acc, we0, we1, er0, er1, rv0, rv1;
      logic [15:0] exp6;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mem_addr", 0, g_dut[0].bus.mem_addr, 16'h0000);
      check("rst_mem_wdata", 1, g_dut[1].bus.mem_wdata, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b1, 1'b0, 1'b1, 16'h0101, 16'h0000, acc);
      check("rd_byte_lat", 0, g_dut[0].rv_cyc - acc, 2);
      check("rd_byte_lat", 1, g_dut[1].rv_cyc - acc, 4);
      check("rd_byte_data", 0, g_dut[0].rv_data, 16'h00A5);
      check("rd_byte_data", 1, g_dut[1].rv_data, 16'h00A5);

      do_req(1'b1, 1'b0, 1'b0, 16'h0234, 16'h0000, acc);
      check("rd_word_lat", 0, g_dut[0].rv_cyc - acc, 4);
      check("rd_word_lat", 1, g_dut[1].rv_cyc - acc, 8);
      check("rd_word_data", 0, g_dut[0].rv_data, 16'hAB12);
      check("rd_word_data", 1, g_dut[1].rv_data, 16'hAB12);

      we0 = g_dut[0].we_cnt;
      we1 = g_dut[1].we_cnt;
      do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'hBEEF, acc);
      check("wr_word_lat", 0, g_dut[0].done_cyc - acc, 2);
      check("wr_word_lat", 1, g_dut[1].done_cyc - acc, 4);
      check("wr_word_strobes", 0, g_dut[0].we_cnt - we0, 2);
      check("wr_word_strobes", 1, g_dut[1].we_cnt - we1, 2);
      do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, acc);
      check("wr_readback", 0, g_dut[0].rv_data, 16'hBEEF);
      check("wr_readback", 1, g_dut[1].rv_data, 16'hBEEF);

      we0 = g_dut[0].we_cnt;
      er0 = g_dut[0].err_cnt;
      er1 = g_dut[1].err_cnt;
      rv0 = g_dut[0].rv_cnt;
      do_req(1'b1, 1'b1, 1'b1, 16'h0010, 16'h005A, acc);
      check("both_err", 0, g_dut[0].err_cnt - er0, 1);
      check("both_err", 1, g_dut[1].err_cnt - er1, 1);
      check("both_one_write", 0, g_dut[0].we_cnt - we0, 1);
      check("both_no_rvalid", 0, g_dut[0].rv_cnt - rv0, 0);
      check("both_mem", 0, g_dut[0].mem[16'h0010], 8'h5A);
      check("both_mem", 1, g_dut[1].mem[16'h0010], 8'h5A);

`ifdef MEMBUS_UNALIGNED_EN
      exp6 = 16'h3322;
`else
      exp6 = 16'h2211;
`endif
      do_req(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, acc);
      check("rd_wrap", 0, g_dut[0].rv_data, exp6);
      check("rd_wrap", 1, g_dut[1].rv_data, exp6);

      do_req(1'b0, 1'b1, 1'b0, 16'h0031, 16'h1234, acc);
      do_req(1'b1, 1'b0, 1'b0, 16'h0031, 16'h0000, acc);
      check("odd_word_rt", 0, g_dut[0].rv_data, 16'h1234);
      do_req(1'b0, 1'b1, 1'b1, 16'h0051, 16'h77C3, acc);
      do_req(1'b1, 1'b0, 1'b1, 16'h0051, 16'h0000, acc);
      check("byte_rt", 1, g_dut[1].rv_data, 16'h00C3);

      // back-to-back: request held high across completions
      s_byt  = 1'b1;
      s_addr = 16'h0234;
      s_rd   = 1'b1;
      repeat (12) @(negedge clk);
      s_rd = 1'b0;
      wait_idle();

      rv0     = g_dut[0].rv_cnt;
      rv1     = g_dut[1].rv_cnt;
      s_wr    = 1'b1;
      s_byt   = 1'b0;
      s_addr  = 16'h4000;
      s_wdata = 16'hCAFE;
      @(posedge clk);
      #1;
      s_wr = 1'b0;
      check("pre_rst_we", 0, g_dut[0].bus.mem_we, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_we_async", 0, g_dut[0].bus.mem_we, 1'b0);
      check("rst_we_async", 1, g_dut[1].bus.mem_we, 1'b0);
      check("rst_busy_async", 0, g_dut[0].bus.busy, 1'b0);
      check("rst_busy_async", 1, g_dut[1].bus.busy, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_no_rvalid", 0, g_dut[0].rv_cnt - rv0, 0);
      check("rst_no_rvalid", 1, g_dut[1].rv_cnt - rv1, 0);
      check("rst_no_write", 1, g_dut[1].mem[16'h4000], init_byte(16'h4000));
      rst_n = 1'b1;
      @(negedge clk);
      do_req(1'b1, 1'b0, 1'b1, 16'h0101, 16'h0000, acc);
      check("post_rst_rd", 1, g_dut[1].rv_data, 16'h00A5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end
endmodule
